// File: rtl/gcd_operand_feeder_if.sv
// Operand-in / pair-out handshake bundle for gcd_operand_feeder.
// slave = feeder side, master = producer/consumer side.
interface gcd_operand_feeder_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic           io_in_valid;
   logic [W-1:0]   io_in_data;
   logic           io_in_ready;
   logic           io_out_valid;
   logic [2*W-1:0] io_out_data;
   logic           io_out_ready;
   logic [CW-1:0]  io_count;
   logic           io_dropped;

   modport slave (
      input  io_in_valid, io_in_data, io_out_ready,
      output io_in_ready, io_out_valid, io_out_data, io_count, io_dropped
   );

   modport master (
      output io_in_valid, io_in_data, io_out_ready,
      input  io_in_ready, io_out_valid, io_out_data, io_count, io_dropped
   );
endinterface

// File: rtl/gcd_operand_feeder.sv
// Pairs serial W-bit operands into {y,x} requests and buffers them in a DEPTH-entry FIFO.
// Optional GCD_FEEDER_ZERO_FILTER_EN: discard pairs with x==0, y!=0 and flag io_dropped.
module gcd_operand_feeder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   gcd_operand_feeder_if.slave   io
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic {PH_Y, PH_X} phase_e;

   phase_e         phase_q, phase_d;
   logic [W-1:0]   hold_q, hold_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [2*W-1:0] mem_q [DEPTH];

   logic discard, full, in_ready, accept, push, pop;

   always_comb begin
      discard = 1'b0;
`ifdef GCD_FEEDER_ZERO_FILTER_EN
      discard = (phase_q == PH_X) && (io.io_in_data == '0) && (hold_q != '0);
`endif
      full     = (count_q == CW'(DEPTH));
      // A discarded pair never occupies a slot, so it ignores FIFO space.
      in_ready = (phase_q == PH_Y) | ~full | io.io_out_ready | discard;
      accept   = io.io_in_valid & in_ready;
      pop      = (count_q != '0) & io.io_out_ready;
      push     = accept & (phase_q == PH_X) & ~discard;

      phase_d  = phase_q;
      hold_d   = hold_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (accept) begin
         if (phase_q == PH_Y) begin
            hold_d  = io.io_in_data;
            phase_d = PH_X;
         end else begin
            phase_d = PH_Y;
         end
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q  <= PH_Y;
         hold_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         phase_q  <= phase_d;
         hold_q   <= hold_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {hold_q, io.io_in_data};
   end

`ifdef GCD_FEEDER_ZERO_FILTER_EN
   logic dropped_q, dropped_d;

   always_comb dropped_d = dropped_q | (accept & discard);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) dropped_q <= 1'b0;
      else       dropped_q <= dropped_d;
   end

   assign io.io_dropped = dropped_q;
`else
   assign io.io_dropped = 1'b0;
`endif

   assign io.io_in_ready  = in_ready;
   assign io.io_out_valid = (count_q != '0);
   assign io.io_out_data  = mem_q[rd_ptr_q];
   assign io.io_count     = count_q;
endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed self-checking bench for gcd_operand_feeder (DEPTH=4, W=16).
module tb_gcd_operand_feeder;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned W     = 16;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   gcd_operand_feeder_if #(.DEPTH(DEPTH), .W(W)) bus ();

   gcd_operand_feeder #(.DEPTH(DEPTH), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] d);
      int n = 0;
      bus.io_in_valid = 1'b1;
      bus.io_in_data  = d;
      while (bus.io_in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         vectors++;
         miscompares++;
         $display("FAIL send_word_timeout data=%h in_ready=%b required=1", d, bus.io_in_ready);
      end
      tick();
      bus.io_in_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [15:0] y, input logic [15:0] x);
      send_word(y);
      send_word(x);
   endtask

   task automatic pop_one();
      bus.io_out_ready = 1'b1;
      tick();
      bus.io_out_ready = 1'b0;
   endtask

   function automatic logic [31:0] full_pair(input int i);
      return {16'(16'h0010 + i), 16'(16'h0100 + i)};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      bus.io_in_valid = 1'b0;
      bus.io_in_data = '0;
      bus.io_out_ready = 1'b0;
      #12;
      vectors++; if (bus.io_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", bus.io_count); end
      vectors++; if (bus.io_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.io_out_valid); end
      vectors++; if (bus.io_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", bus.io_in_ready); end
      vectors++; if (bus.io_dropped !== 1'b0) begin miscompares++; $display("FAIL reset_dropped got=%b exp=0", bus.io_dropped); end
      @(negedge clk) reset = 1'b0;
      tick();
      send_pair(16'h0001, 16'h0002);
      send_pair(16'h0003, 16'h0004);
      vectors++; if (bus.io_count !== 3'd2) begin miscompares++; $display("FAIL pre_reset_count got=%0d exp=2", bus.io_count); end
      send_word(16'h0099);
      #2 reset = 1'b1;
      #1;
      vectors++; if (bus.io_count !== 3'd0) begin miscompares++; $display("FAIL async_reset_count got=%0d exp=0", bus.io_count); end
      vectors++; if (bus.io_out_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_valid got=%b exp=0", bus.io_out_valid); end
      vectors++; if (bus.io_in_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset_ready got=%b exp=1", bus.io_in_ready); end
      @(negedge clk) reset = 1'b0;
      tick();
      send_pair(16'h00AA, 16'h00BB);
      vectors++; if (bus.io_out_data !== 32'h00AA00BB) begin miscompares++; $display("FAIL reset_half_pair_lost got=%h exp=00aa00bb", bus.io_out_data); end
      vectors++; if (bus.io_count !== 3'd1) begin miscompares++; $display("FAIL post_reset_count got=%0d exp=1", bus.io_count); end
      pop_one();
      vectors++; if (bus.io_count !== 3'd0) begin miscompares++; $display("FAIL post_reset_pop got=%0d exp=0", bus.io_count); end
   endtask

   task automatic test_pairing();
      send_pair(16'h0030, 16'h0012);
      vectors++; if (bus.io_out_valid !== 1'b1) begin miscompares++; $display("FAIL pair_valid got=%b exp=1", bus.io_out_valid); end
      vectors++; if (bus.io_out_data !== 32'h00300012) begin miscompares++; $display("FAIL pair_data got=%h exp=00300012", bus.io_out_data); end
      vectors++; if (bus.io_count !== 3'd1) begin miscompares++; $display("FAIL pair_count got=%0d exp=1", bus.io_count); end
      pop_one();
      vectors++; if (bus.io_out_valid !== 1'b0) begin miscompares++; $display("FAIL pair_drain got=%b exp=0", bus.io_out_valid); end
   endtask

   task automatic test_full();
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) begin
         exp = full_pair(i);
         send_pair(exp[31:16], exp[15:0]);
      end
      vectors++; if (bus.io_count !== 3'd4) begin miscompares++; $display("FAIL full_count got=%0d exp=4", bus.io_count); end
      bus.io_in_valid = 1'b1;
      bus.io_in_data  = 16'h0055;
      #1;
      vectors++; if (bus.io_in_ready !== 1'b1) begin miscompares++; $display("FAIL full_first_word_ready got=%b exp=1", bus.io_in_ready); end
      tick();
      bus.io_in_data = 16'h0005;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++; if (bus.io_in_ready !== 1'b0) begin miscompares++; $display("FAIL full_backpressure cyc=%0d got=%b exp=0", c, bus.io_in_ready); end
         tick();
      end
      bus.io_out_ready = 1'b1;
      #1;
      vectors++; if (bus.io_in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop_ready got=%b exp=1", bus.io_in_ready); end
      tick();
      bus.io_in_valid  = 1'b0;
      bus.io_out_ready = 1'b0;
      vectors++; if (bus.io_count !== 3'd4) begin miscompares++; $display("FAIL full_push_pop_count got=%0d exp=4", bus.io_count); end
      for (int i = 1; i < 4; i++) begin
         exp = full_pair(i);
         vectors++; if (bus.io_out_data !== exp) begin miscompares++; $display("FAIL full_drain_%0d got=%h exp=%h", i, bus.io_out_data, exp); end
         pop_one();
      end
      vectors++; if (bus.io_out_data !== 32'h00550005) begin miscompares++; $display("FAIL full_drain_last got=%h exp=00550005", bus.io_out_data); end
      pop_one();
      vectors++; if (bus.io_count !== 3'd0) begin miscompares++; $display("FAIL full_empty got=%0d exp=0", bus.io_count); end
   endtask

   task automatic test_order_wrap();
      logic [15:0] words [12];
      logic [31:0] q [$];
      int sent = 0;
      int cyc = 0;
      logic acc, pp;
      for (int i = 0; i < 12; i++) words[i] = 16'(16'h0A00 + 16'(i * 17) + 16'd1);
      while ((sent < 12 || q.size() != 0) && cyc < 200) begin
         bus.io_in_valid  = (sent < 12);
         bus.io_in_data   = (sent < 12) ? words[sent] : 16'h0000;
         bus.io_out_ready = (cyc % 3 == 2);
         #1;
         acc = bus.io_in_valid & bus.io_in_ready;
         pp  = bus.io_out_valid & bus.io_out_ready;
         if (pp) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL order_unexpected_pop got=%h exp=none", bus.io_out_data);
            end else begin
               if (bus.io_out_data !== q[0]) begin miscompares++; $display("FAIL order_data got=%h exp=%h", bus.io_out_data, q[0]); end
               void'(q.pop_front());
            end
         end
         if (acc) begin
            if (sent % 2 == 1) q.push_back({words[sent-1], words[sent]});
            sent++;
         end
         tick();
         cyc++;
         vectors++; if (bus.io_count !== 3'(q.size())) begin miscompares++; $display("FAIL order_count cyc=%0d got=%0d exp=%0d", cyc, bus.io_count, q.size()); end
      end
      bus.io_in_valid  = 1'b0;
      bus.io_out_ready = 1'b0;
      vectors++; if (cyc >= 200) begin miscompares++; $display("FAIL order_timeout got=%0d exp=<200", cyc); end
   endtask

   task automatic test_stall();
      send_pair(16'h1111, 16'h2222);
      send_pair(16'h3333, 16'h4444);
      for (int c = 0; c < 5; c++) begin
         vectors++; if (bus.io_out_valid !== 1'b1 || bus.io_out_data !== 32'h11112222) begin miscompares++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/11112222", c, bus.io_out_valid, bus.io_out_data); end
         tick();
      end
      pop_one();
      vectors++; if (bus.io_out_data !== 32'h33334444) begin miscompares++; $display("FAIL stall_next got=%h exp=33334444", bus.io_out_data); end
      vectors++; if (bus.io_count !== 3'd1) begin miscompares++; $display("FAIL stall_count got=%0d exp=1", bus.io_count); end
      pop_one();
   endtask

   task automatic test_filter();
      send_pair(16'h0007, 16'h0000);
`ifdef GCD_FEEDER_ZERO_FILTER_EN
      vectors++; if (bus.io_count !== 3'd0) begin miscompares++; $display("FAIL filter_drop_count got=%0d exp=0", bus.io_count); end
      vectors++; if (bus.io_dropped !== 1'b1) begin miscompares++; $display("FAIL filter_dropped got=%b exp=1", bus.io_dropped); end
      send_pair(16'h0000, 16'h0000);
      vectors++; if (bus.io_count !== 3'd1 || bus.io_out_data !== 32'h0) begin miscompares++; $display("FAIL filter_zero_pair got=%0d/%h exp=1/00000000", bus.io_count, bus.io_out_data); end
      for (int i = 0; i < 3; i++) send_pair(16'h0100, 16'h0001);
      send_word(16'h0005);
      bus.io_in_valid = 1'b1;
      bus.io_in_data  = 16'h0000;
      #1;
      vectors++; if (bus.io_in_ready !== 1'b1) begin miscompares++; $display("FAIL filter_full_ready got=%b exp=1", bus.io_in_ready); end
      tick();
      bus.io_in_valid = 1'b0;
      vectors++; if (bus.io_count !== 3'd4) begin miscompares++; $display("FAIL filter_full_count got=%0d exp=4", bus.io_count); end
      for (int i = 0; i < 4; i++) pop_one();
`else
      vectors++; if (bus.io_count !== 3'd1 || bus.io_out_data !== 32'h00070000) begin miscompares++; $display("FAIL nofilter_push got=%0d/%h exp=1/00070000", bus.io_count, bus.io_out_data); end
      vectors++; if (bus.io_dropped !== 1'b0) begin miscompares++; $display("FAIL nofilter_dropped got=%b exp=0", bus.io_dropped); end
      send_pair(16'h0000, 16'h0000);
      vectors++; if (bus.io_count !== 3'd2) begin miscompares++; $display("FAIL nofilter_zero_pair got=%0d exp=2", bus.io_count); end
      for (int i = 0; i < 2; i++) pop_one();
`endif
      vectors++; if (bus.io_count !== 3'd0) begin miscompares++; $display("FAIL filter_drain got=%0d exp=0", bus.io_count); end
   endtask

   initial begin
      test_reset();
      test_pairing();
      test_full();
      test_order_wrap();
      test_stall();
      test_filter();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t limit=200000", $time);
      $fatal(1, "watchdog");
   end
endmodule
